// File: rtl/eu_dispatch_pkg.sv
// Shared types and constants for the execution-unit dispatch sequencer.
package eu_dispatch_pkg;

  localparam int unsigned UNIT_W   = 5;
  localparam int unsigned STROBE_W = 32;
  localparam int unsigned DONE_W   = 28;
  localparam int unsigned ADDR_W   = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_FETCH = 2'b01,
    OP_EXEC  = 2'b10,
    OP_SYNC  = 2'b11
  } op_e;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_WAIT_IDLE  = 3'd1;
  localparam state_t ST_ISSUE      = 3'd2;
  localparam state_t ST_GUARD      = 3'd3;
  localparam state_t ST_WAIT_FETCH = 3'd4;
  localparam state_t ST_WAIT_ALL   = 3'd5;

  localparam int unsigned STMM_BASE = 0;
  localparam int unsigned LN_BASE   = 4;
  localparam int unsigned LUT_BASE  = 8;

  localparam logic [UNIT_W-1:0] SYNC_ERR_UNIT = 5'd31;

  function automatic logic [STROBE_W-1:0] unit_onehot(input logic [UNIT_W-1:0] unit);
    return STROBE_W'(1) << unit;
  endfunction

endpackage

// File: rtl/eu_dispatch_timer.sv
// Loadable free-running up-counter with a terminal-count compare.
module eu_dispatch_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         hit_c
);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else           cnt <= cnt + W'(1);
  end

  assign hit_c = (cnt == term);

endmodule

// File: rtl/eu_dispatch_ctrl.sv
// Command sequencer between the control unit and the EU top: serialises fetches,
// waits for target units to go idle, issues one-hot strobes and flags hangs.
module eu_dispatch_ctrl
  import eu_dispatch_pkg::*;
#(
  parameter int unsigned NUM_UNITS      = 12,
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [UNIT_W-1:0]   cmd_unit,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic                fetch_done,
  input  logic [DONE_W-1:0]   exec_done,
  output logic [UNIT_W-1:0]   sdram_read_sel,
  output logic [STROBE_W-1:0] eu_fetch,
  output logic [STROBE_W-1:0] eu_exec,
  output logic [ADDR_W-1:0]   eu_fetch_addr,
  output logic                busy,
  input  logic                err_clr,
  output logic                err_timeout,
  output logic                err_badunit,
  output logic [UNIT_W-1:0]   err_unit,
  output logic [CNT_W-1:0]    issued_cnt
);

  localparam int unsigned TMAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [STROBE_W-1:0] UNIT_MASK = STROBE_W'((64'(1) << NUM_UNITS) - 64'(1));

  state_t              state, state_nxt;
  op_e                 op_q;
  logic [UNIT_W-1:0]   unit_q;
  logic [ADDR_W-1:0]   addr_q;

  op_e                 cmd_op_e;
  logic                accept_c, unit_ok_c, wait_ok_c, all_done_c;
  logic                bad_unit_c, timeout_ev_c, issue_c, err_ev_c, load_c;
  logic [UNIT_W-1:0]   err_ev_unit_c;
  state_t              post_guard_c;
  logic [STROBE_W-1:0] exec_done_ext;
  logic [TW-1:0]       tcnt, tterm_c;
  logic                thit_c;

  assign exec_done_ext = STROBE_W'(exec_done);

  // One counter serves both the guard window and the wait-state timeout
  eu_dispatch_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .load_val ('0),
    .term     (tterm_c),
    .cnt      (tcnt),
    .hit_c    (thit_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; the guard window spans the ISSUE cycle plus the GUARD state
  always_comb begin
    state_nxt     = state;
    bad_unit_c    = 1'b0;
    timeout_ev_c  = 1'b0;
    cmd_op_e      = op_e'(cmd_op);
    accept_c      = cmd_valid & cmd_ready;
    unit_ok_c     = 32'(cmd_unit) < NUM_UNITS;
    wait_ok_c     = exec_done_ext[unit_q] && ((op_q != OP_FETCH) || fetch_done);
    all_done_c    = fetch_done && (&(exec_done_ext | ~UNIT_MASK));
    post_guard_c  = (op_q == OP_FETCH) ? ST_WAIT_FETCH : ST_IDLE;
    tterm_c       = (state == ST_GUARD) ? TW'(GUARD_CYCLES - 1) : TW'(TIMEOUT_CYCLES - 1);

    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          case (cmd_op_e)
            OP_FETCH, OP_EXEC: begin
              if (unit_ok_c) state_nxt = ST_WAIT_IDLE;
              else           bad_unit_c = 1'b1;
            end
            OP_SYNC: state_nxt = ST_WAIT_ALL;
            default: ;
          endcase
        end
      end
      ST_WAIT_IDLE: begin
        if (wait_ok_c) state_nxt = ST_ISSUE;
        else if (thit_c) begin
          state_nxt    = ST_IDLE;
          timeout_ev_c = 1'b1;
        end
      end
      ST_ISSUE: state_nxt = (GUARD_CYCLES > 1) ? ST_GUARD : post_guard_c;
      ST_GUARD: if (thit_c) state_nxt = post_guard_c;
      ST_WAIT_FETCH: begin
        if (fetch_done) state_nxt = ST_IDLE;
        else if (thit_c) begin
          state_nxt    = ST_IDLE;
          timeout_ev_c = 1'b1;
        end
      end
      ST_WAIT_ALL: begin
        if (all_done_c) state_nxt = ST_IDLE;
        else if (thit_c) begin
          state_nxt    = ST_IDLE;
          timeout_ev_c = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    issue_c       = (state == ST_WAIT_IDLE) && (state_nxt == ST_ISSUE);
    load_c        = (state_nxt != state) && (state_nxt != ST_GUARD);
    err_ev_c      = bad_unit_c | timeout_ev_c;
    err_ev_unit_c = bad_unit_c ? cmd_unit : ((op_q == OP_SYNC) ? SYNC_ERR_UNIT : unit_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q           <= OP_NOP;
      unit_q         <= '0;
      addr_q         <= '0;
      cmd_ready      <= 1'b0;
      busy           <= 1'b0;
      eu_fetch       <= '0;
      eu_exec        <= '0;
      sdram_read_sel <= '0;
      eu_fetch_addr  <= '0;
      issued_cnt     <= '0;
      err_timeout    <= 1'b0;
      err_badunit    <= 1'b0;
      err_unit       <= '0;
    end else begin
      if (accept_c) begin
        op_q   <= cmd_op_e;
        unit_q <= cmd_unit;
        addr_q <= cmd_addr;
      end
      cmd_ready <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);
      eu_fetch  <= '0;
      eu_exec   <= '0;
      if (issue_c) begin
        if (op_q == OP_FETCH) begin
          eu_fetch       <= unit_onehot(unit_q);
          sdram_read_sel <= unit_q;
          eu_fetch_addr  <= addr_q;
        end else begin
          eu_exec <= unit_onehot(unit_q);
        end
        issued_cnt <= issued_cnt + CNT_W'(1);
      end
      // A clear coinciding with a fresh error keeps the fresh error
      if (err_clr) begin
        err_timeout <= timeout_ev_c;
        err_badunit <= bad_unit_c;
        err_unit    <= err_ev_c ? err_ev_unit_c : '0;
      end else begin
        if (timeout_ev_c) err_timeout <= 1'b1;
        if (bad_unit_c)   err_badunit <= 1'b1;
        if (err_ev_c && !err_timeout && !err_badunit) err_unit <= err_ev_unit_c;
      end
    end
  end

endmodule

// File: tb/tb_eu_dispatch_ctrl.sv
// Directed bench for eu_dispatch_ctrl: a default-timeout instance plus a short-timeout one.
module tb_eu_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_valid_t;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_unit;
  logic [31:0] cmd_addr;
  logic        fetch_done;
  logic [27:0] exec_done;
  logic        err_clr;

  logic        cmd_ready, busy, err_timeout, err_badunit;
  logic [4:0]  sdram_read_sel, err_unit;
  logic [31:0] eu_fetch, eu_exec, eu_fetch_addr;
  logic [15:0] issued_cnt;

  logic        t_cmd_ready, t_busy, t_err_timeout, t_err_badunit;
  logic [4:0]  t_sdram_read_sel, t_err_unit;
  logic [31:0] t_eu_fetch, t_eu_exec, t_eu_fetch_addr;
  logic [15:0] t_issued_cnt;

  int vectors = 0;
  int miscompares = 0;
  int nstrobe, nrdy, first_k, second_k;
  logic [31:0] ex_hist [1:8];
  logic        rdy_hist [1:8];

  always #5 clk = ~clk;

  eu_dispatch_ctrl #(.NUM_UNITS(12), .GUARD_CYCLES(2), .TIMEOUT_CYCLES(65535), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_unit(cmd_unit), .cmd_addr(cmd_addr), .fetch_done(fetch_done), .exec_done(exec_done),
    .sdram_read_sel(sdram_read_sel), .eu_fetch(eu_fetch), .eu_exec(eu_exec),
    .eu_fetch_addr(eu_fetch_addr), .busy(busy), .err_clr(err_clr), .err_timeout(err_timeout),
    .err_badunit(err_badunit), .err_unit(err_unit), .issued_cnt(issued_cnt)
  );

  eu_dispatch_ctrl #(.NUM_UNITS(12), .GUARD_CYCLES(2), .TIMEOUT_CYCLES(16), .CNT_W(16)) dut_to (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_t), .cmd_ready(t_cmd_ready), .cmd_op(cmd_op),
    .cmd_unit(cmd_unit), .cmd_addr(cmd_addr), .fetch_done(fetch_done), .exec_done(exec_done),
    .sdram_read_sel(t_sdram_read_sel), .eu_fetch(t_eu_fetch), .eu_exec(t_eu_exec),
    .eu_fetch_addr(t_eu_fetch_addr), .busy(t_busy), .err_clr(err_clr), .err_timeout(t_err_timeout),
    .err_badunit(t_err_badunit), .err_unit(t_err_unit), .issued_cnt(t_issued_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid_t = 1'b0; cmd_op = 2'b00; cmd_unit = '0;
    cmd_addr = '0; fetch_done = 1'b0; exec_done = '0; err_clr = 1'b0;
    step(); step();
    chk("rst_ready", 32'(cmd_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_exec", eu_exec, 32'h0);
    chk("rst_issued", 32'(issued_cnt), 32'h0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(cmd_ready), 32'h1);

    // EXEC unit 2 held off by its busy unit
    exec_done = 28'hFFF_FFFB; fetch_done = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_unit = 5'd2;
    step();
    cmd_valid = 1'b0;
    nstrobe = 0;
    for (int i = 0; i < 20; i++) begin
      if (eu_exec != 0) nstrobe++;
      step();
    end
    chk("exec2_blocked_strobes", 32'(nstrobe), 32'h0);
    chk("exec2_blocked_ready", 32'(cmd_ready), 32'h0);
    exec_done = 28'hFFF_FFFF;
    step();
    chk("exec2_strobe", eu_exec, 32'h4);
    chk("exec2_issued", 32'(issued_cnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (eu_exec != 0) nstrobe++;
    end
    chk("exec2_single", 32'(nstrobe), 32'h0);
    chk("exec2_ready_back", 32'(cmd_ready), 32'h1);

    // Back-to-back EXEC 0 then EXEC 1
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_unit = 5'd0;
    step();
    cmd_unit = 5'd1;
    ex_hist[1] = eu_exec; rdy_hist[1] = cmd_ready;
    for (int k = 2; k <= 8; k++) begin
      step();
      if (k == 5) cmd_valid = 1'b0;
      ex_hist[k] = eu_exec; rdy_hist[k] = cmd_ready;
    end
    first_k = 0; second_k = 0;
    for (int k = 1; k <= 8; k++) begin
      if (ex_hist[k] != 0) begin
        if (first_k == 0) first_k = k;
        else if (second_k == 0) second_k = k;
      end
    end
    chk("b2b_first_at", 32'(first_k), 32'd2);
    chk("b2b_first_val", ex_hist[2], 32'h1);
    chk("b2b_second_val", ex_hist[6], 32'h2);
    chk("b2b_separation", 32'(second_k - first_k), 32'd4);
    chk("b2b_ready_c3", 32'(rdy_hist[3]), 32'h0);
    chk("b2b_ready_c4", 32'(rdy_hist[4]), 32'h1);
    chk("b2b_ready_c8", 32'(rdy_hist[8]), 32'h1);
    chk("b2b_issued", 32'(issued_cnt), 32'd3);

    // FETCH unit 5 @ 0x1000
    fetch_done = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_unit = 5'd5; cmd_addr = 32'h0000_1000;
    step();
    cmd_valid = 1'b0;
    chk("fetch_wait_busy", 32'(busy), 32'h1);
    chk("fetch_wait_nostrobe", eu_fetch, 32'h0);
    step();
    chk("fetch_strobe", eu_fetch, 32'h20);
    chk("fetch_sel", 32'(sdram_read_sel), 32'd5);
    chk("fetch_addr", eu_fetch_addr, 32'h0000_1000);
    chk("fetch_issued", 32'(issued_cnt), 32'd4);
    step();
    chk("fetch_strobe_1cyc", eu_fetch, 32'h0);
    fetch_done = 1'b0;
    repeat (10) step();
    chk("fetch_wait_ready", 32'(cmd_ready), 32'h0);
    fetch_done = 1'b1;
    step();
    chk("fetch_done_ready", 32'(cmd_ready), 32'h1);
    chk("fetch_sel_held", 32'(sdram_read_sel), 32'd5);
    chk("fetch_addr_held", eu_fetch_addr, 32'h0000_1000);

    // SYNC blocked by unit 9
    exec_done = 28'hFFF_FDFF;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_unit = 5'd0;
    step();
    cmd_valid = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 30; i++) begin
      if (cmd_ready) nrdy++;
      step();
    end
    chk("sync_ready_low", 32'(nrdy), 32'h0);
    exec_done = 28'hFFF_FFFF;
    step();
    chk("sync_ready_high", 32'(cmd_ready), 32'h1);
    chk("sync_busy_low", 32'(busy), 32'h0);

    // Bad unit, first-error capture and clear behaviour
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_unit = 5'd12; cmd_addr = 32'h0000_2222;
    step();
    chk("bad_flag", 32'(err_badunit), 32'h1);
    chk("bad_unit", 32'(err_unit), 32'd12);
    chk("bad_nostrobe", eu_fetch, 32'h0);
    chk("bad_stay_idle", 32'(cmd_ready), 32'h1);
    chk("bad_issued", 32'(issued_cnt), 32'd4);
    cmd_op = 2'b10; cmd_unit = 5'd20;
    step();
    chk("bad_first_only", 32'(err_unit), 32'd12);
    cmd_valid = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_badunit", 32'(err_badunit), 32'h0);
    chk("clr_unit", 32'(err_unit), 32'h0);
    chk("clr_timeout", 32'(err_timeout), 32'h0);
    err_clr = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_unit = 5'd15;
    step();
    err_clr = 1'b0; cmd_valid = 1'b0;
    chk("clr_vs_new_flag", 32'(err_badunit), 32'h1);
    chk("clr_vs_new_unit", 32'(err_unit), 32'd15);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_again", 32'(err_badunit), 32'h0);

    // Short-timeout instance: FETCH with fetch_done stuck low
    fetch_done = 1'b1;
    cmd_valid_t = 1'b1; cmd_op = 2'b01; cmd_unit = 5'd3; cmd_addr = 32'hABCD_0040;
    step();
    cmd_valid_t = 1'b0;
    step();
    chk("to_strobe", t_eu_fetch, 32'h8);
    fetch_done = 1'b0;
    step();
    step();
    repeat (15) step();
    chk("to_not_yet", 32'(t_err_timeout), 32'h0);
    chk("to_busy", 32'(t_busy), 32'h1);
    step();
    chk("to_flag", 32'(t_err_timeout), 32'h1);
    chk("to_idle", 32'(t_busy), 32'h0);
    chk("to_ready", 32'(t_cmd_ready), 32'h1);
    chk("to_unit", 32'(t_err_unit), 32'd3);
    chk("to_nostrobe", t_eu_fetch, 32'h0);

    // Reset in the middle of a wait
    cmd_valid_t = 1'b1; cmd_op = 2'b11;
    step();
    cmd_valid_t = 1'b0;
    step(); step();
    chk("midrst_busy_before", 32'(t_busy), 32'h1);
    rst = 1'b1;
    step();
    chk("midrst_ready", 32'(t_cmd_ready), 32'h0);
    chk("midrst_busy", 32'(t_busy), 32'h0);
    chk("midrst_err", 32'({t_err_timeout, t_err_badunit}), 32'h0);
    chk("midrst_err_unit", 32'(t_err_unit), 32'h0);
    chk("midrst_issued", 32'(t_issued_cnt), 32'h0);
    chk("midrst_sel", 32'(t_sdram_read_sel), 32'h0);
    chk("midrst_addr", t_eu_fetch_addr, 32'h0);
    chk("midrst_strobes", t_eu_fetch | t_eu_exec, 32'h0);
    rst = 1'b0;
    step();
    chk("midrst_ready_after", 32'(t_cmd_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eu_dispatch_ctrl.md
Name: eu_dispatch_ctrl

Overview:
Sequencer between the control unit and the execution-unit top. Accepts one command at a time (FETCH, EXEC, SYNC) over a valid/ready handshake. Steers the shared SDRAM read mux and issues single-cycle one-hot fetch/exec strobes to EU sub-units. Serialises fetches on the shared read port, prevents starting a unit that is still executing, and flags hangs with a timeout.

Parameters:
NUM_UNITS, 12, populated sub-units (indices 0..NUM_UNITS-1); stmm 0-3, layernorm 4-7, lut 8-11
GUARD_CYCLES, 2, cycles after a strobe during which done inputs are ignored (min 1)
TIMEOUT_CYCLES, 65535, max cycles in any wait state before abort
CNT_W, 16, width of the issue counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  dispatcher can accept
cmd_op  in  2  00 NOP, 01 FETCH, 10 EXEC, 11 SYNC
cmd_unit  in  5  target sub-unit index
cmd_addr  in  32  SDRAM fetch address (FETCH only)
fetch_done  in  1  AND of all unit fetch-done levels
exec_done  in  28  per-unit exec-done levels; bits >= NUM_UNITS ignored
sdram_read_sel  out  5  read-mux select
eu_fetch  out  32  one-hot fetch strobe
eu_exec  out  32  one-hot exec strobe
eu_fetch_addr  out  32  fetch address to units
busy  out  1  state != IDLE
err_clr  in  1  clears sticky errors
err_timeout  out  1  sticky timeout flag
err_badunit  out  1  sticky: FETCH/EXEC to unit >= NUM_UNITS
err_unit  out  5  unit of first error since clear
issued_cnt  out  CNT_W  strobes issued, wraps

Behaviour:
- Reset: all outputs 0; state IDLE; cmd_ready = 0 during reset, 1 on the first cycle after it.
- cmd_ready = (state == IDLE). Accept on cmd_valid & cmd_ready. Command latched in the same cycle.
- Accept decode:
  - NOP: stay IDLE.
  - FETCH/EXEC with unit >= NUM_UNITS: drop, set err_badunit, stay IDLE.
  - FETCH/EXEC otherwise: go to WAIT_IDLE.
  - SYNC: go to WAIT_ALL.
- WAIT_IDLE: proceed to ISSUE when exec_done[unit] == 1, and for FETCH also fetch_done == 1. Same cycle the condition is seen -> ISSUE next cycle.
- ISSUE (exactly 1 cycle):
  - FETCH: eu_fetch[unit] = 1; sdram_read_sel and eu_fetch_addr are loaded from the latched command at ISSUE entry and held until the next FETCH ISSUE.
  - EXEC: eu_exec[unit] = 1.
  - issued_cnt++. Strobes are 0 in every other state.
- GUARD: GUARD_CYCLES cycles with done inputs ignored. Then FETCH -> WAIT_FETCH; EXEC -> IDLE (EXEC is non-blocking).
- WAIT_FETCH: fetch_done == 1 -> IDLE.
- WAIT_ALL: fetch_done == 1 and all exec_done[NUM_UNITS-1:0] == 1 -> IDLE.
- Timeout:
  - Counter reset on entering WAIT_IDLE, WAIT_FETCH or WAIT_ALL; increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES: set err_timeout, go IDLE, no strobe.
  - err_unit = latched unit (SYNC reports 31).
- err_unit records only the first error after reset or err_clr.
- err_clr clears both error flags and err_unit. If err_clr and a new error occur in the same cycle, the new error wins.
- A done input that is already high in WAIT_* completes the wait in 1 cycle.
- Minimum latencies: EXEC accept to strobe = 2 cycles. EXEC accept to cmd_ready again = 2 + GUARD_CYCLES.
- Reset mid-operation returns to IDLE next cycle. Any strobe in flight is dropped; strobe outputs are 0 that cycle.

Decomposition:
- Package eu_dispatch_pkg: op enum (OP_NOP/FETCH/EXEC/SYNC), state enum (IDLE, WAIT_IDLE, ISSUE, GUARD, WAIT_FETCH, WAIT_ALL), unit-group base constants (STMM_BASE=0, LN_BASE=4, LUT_BASE=8), SYNC_ERR_UNIT=31.
- One sub-module, eu_dispatch_timer: loadable up-counter with terminal flag, reused for the GUARD count and the timeout count.

Test Plan:
- FETCH unit 5, addr 0x0000_1000, fetch_done held high -> 2 cycles later eu_fetch = 0x20 for 1 cycle; sdram_read_sel = 5; eu_fetch_addr = 0x1000. fetch_done dropped 1 cycle after the strobe and raised 10 cycles later -> cmd_ready rises the cycle after.
- EXEC unit 2 while exec_done[2] = 0 for 20 cycles -> no strobe until exec_done[2] = 1, then eu_exec = 0x4 exactly once; issued_cnt = 1.
- Back-to-back EXEC 0 and EXEC 1 with both dones high -> strobes 0x1 then 0x2, separated by 2 + GUARD_CYCLES cycles.
- SYNC with exec_done[9] = 0 for 30 cycles -> cmd_ready low throughout, high 1 cycle after exec_done[9] rises.
- FETCH unit 12 -> no strobe; err_badunit = 1; err_unit = 12. Then err_clr -> both cleared.
- TIMEOUT_CYCLES = 16, FETCH with fetch_done stuck 0 after the strobe -> err_timeout set after 16 WAIT_FETCH cycles; state IDLE; mid-wait rst -> all outputs 0 next cycle.
